// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icodes, register IDs, stat codes and E-register type
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } eReg_t;

  localparam eReg_t E_BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0,
                                 valC: 64'd0, valA: 64'd0, valB: 64'd0,
                                 dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

endpackage

// File: rtl/y86_decode_stage_if.sv
// rtl/y86_decode_stage_if.sv - D-register, forwarding taps and E-register bundle
interface y86_decode_stage_if;
  logic        F_stall_i;
  logic        F_bubble_i;
  logic [63:0] f_predPC_i;
  logic [63:0] F_predPC_o;

  logic [2:0]  D_stat_i;
  logic [3:0]  D_icode_i;
  logic [3:0]  D_ifun_i;
  logic [3:0]  D_rA_i;
  logic [3:0]  D_rB_i;
  logic [63:0] D_valC_i;
  logic [63:0] D_valP_i;

  logic [3:0]  e_dstE_i;
  logic [63:0] e_valE_i;
  logic [3:0]  M_dstE_i;
  logic [3:0]  M_dstM_i;
  logic [63:0] M_valE_i;
  logic [63:0] m_valM_i;
  logic [3:0]  W_dstE_i;
  logic [3:0]  W_dstM_i;
  logic [63:0] W_valE_i;
  logic [63:0] W_valM_i;

  logic        E_stall_i;
  logic        E_bubble_i;

  logic [3:0]  d_srcA_o;
  logic [3:0]  d_srcB_o;
  logic [2:0]  E_stat_o;
  logic [3:0]  E_icode_o;
  logic [3:0]  E_ifun_o;
  logic [3:0]  E_dstE_o;
  logic [3:0]  E_dstM_o;
  logic [3:0]  E_srcA_o;
  logic [3:0]  E_srcB_o;
  logic [63:0] E_valC_o;
  logic [63:0] E_valA_o;
  logic [63:0] E_valB_o;

  // master drives the stage inputs (pipeline side), slave is the decode stage
  modport master (
    output F_stall_i, F_bubble_i, f_predPC_i,
    output D_stat_i, D_icode_i, D_ifun_i, D_rA_i, D_rB_i, D_valC_i, D_valP_i,
    output e_dstE_i, e_valE_i, M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
    output W_dstE_i, W_dstM_i, W_valE_i, W_valM_i,
    output E_stall_i, E_bubble_i,
    input  F_predPC_o, d_srcA_o, d_srcB_o,
    input  E_stat_o, E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o,
    input  E_valC_o, E_valA_o, E_valB_o
  );

  modport slave (
    input  F_stall_i, F_bubble_i, f_predPC_i,
    input  D_stat_i, D_icode_i, D_ifun_i, D_rA_i, D_rB_i, D_valC_i, D_valP_i,
    input  e_dstE_i, e_valE_i, M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
    input  W_dstE_i, W_dstM_i, W_valE_i, W_valM_i,
    input  E_stall_i, E_bubble_i,
    output F_predPC_o, d_srcA_o, d_srcB_o,
    output E_stat_o, E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o,
    output E_valC_o, E_valA_o, E_valB_o
  );
endinterface

// File: rtl/y86_regfile.sv
// rtl/y86_regfile.sv - 15x64 register file, two combinational reads, two writes
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] valA,
  output logic [63:0] valB,
  input  logic [3:0]  dstE,
  input  logic [63:0] valE,
  input  logic [3:0]  dstM,
  input  logic [63:0] valM
);

  logic [63:0] regs [15];

  // valM write is issued last so it wins when dstE == dstM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) regs[i] <= 64'd0;
    end else begin
      if (dstE != RNONE) regs[dstE] <= valE;
      if (dstM != RNONE) regs[dstM] <= valM;
    end
  end

  assign valA = (srcA == RNONE) ? 64'd0 : regs[srcA];
  assign valB = (srcB == RNONE) ? 64'd0 : regs[srcB];

endmodule

// File: rtl/y86_decode_stage.sv
// rtl/y86_decode_stage.sv - F predPC register, decode with forwarding, D->E register
// Define DECODE_FORWARD_EN to enable the e/M/W forwarding chain.
module y86_decode_stage
  import y86_pkg::*;
(
  input logic             clk_i,
  input logic             rst_i,
  y86_decode_stage_if.slave bus
);

  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] rfValA, rfValB, selA, selB;
  logic [63:0] predPC;
  eReg_t       eReg, eNext;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (bus.D_icode_i)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = bus.D_rA_i;
      I_POPQ, I_RET:                      srcA = RSP;
      default:                            srcA = RNONE;
    endcase
    case (bus.D_icode_i)
      I_OPQ, I_RMMOVQ, I_MRMOVQ:          srcB = bus.D_rB_i;
      I_PUSHQ, I_POPQ, I_CALL, I_RET:     srcB = RSP;
      default:                            srcB = RNONE;
    endcase
    case (bus.D_icode_i)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          dstE = bus.D_rB_i;
      I_PUSHQ, I_POPQ, I_CALL, I_RET:     dstE = RSP;
      default:                            dstE = RNONE;
    endcase
    case (bus.D_icode_i)
      I_MRMOVQ, I_POPQ:                   dstM = bus.D_rA_i;
      default:                            dstM = RNONE;
    endcase
  end

  y86_regfile u_regfile (
    .clk  (clk_i),
    .rst  (rst_i),
    .srcA (srcA),
    .srcB (srcB),
    .valA (rfValA),
    .valB (rfValB),
    .dstE (bus.W_dstE_i),
    .valE (bus.W_valE_i),
    .dstM (bus.W_dstM_i),
    .valM (bus.W_valM_i)
  );

  // Youngest producer first; the W taps double as the write-through for same-cycle writes
  always_comb begin
    selA = rfValA;
    selB = rfValB;
`ifdef DECODE_FORWARD_EN
    if (srcA == RNONE)                selA = rfValA;
    else if (srcA == bus.e_dstE_i)    selA = bus.e_valE_i;
    else if (srcA == bus.M_dstM_i)    selA = bus.m_valM_i;
    else if (srcA == bus.M_dstE_i)    selA = bus.M_valE_i;
    else if (srcA == bus.W_dstM_i)    selA = bus.W_valM_i;
    else if (srcA == bus.W_dstE_i)    selA = bus.W_valE_i;
    if (srcB == RNONE)                selB = rfValB;
    else if (srcB == bus.e_dstE_i)    selB = bus.e_valE_i;
    else if (srcB == bus.M_dstM_i)    selB = bus.m_valM_i;
    else if (srcB == bus.M_dstE_i)    selB = bus.M_valE_i;
    else if (srcB == bus.W_dstM_i)    selB = bus.W_valM_i;
    else if (srcB == bus.W_dstE_i)    selB = bus.W_valE_i;
`endif
    if (bus.D_icode_i == I_CALL || bus.D_icode_i == I_JXX) selA = bus.D_valP_i;
  end

  always_comb begin
    eNext       = E_BUBBLE;
    eNext.stat  = bus.D_stat_i;
    eNext.icode = bus.D_icode_i;
    eNext.ifun  = bus.D_ifun_i;
    eNext.valC  = bus.D_valC_i;
    eNext.valA  = selA;
    eNext.valB  = selB;
    eNext.dstE  = dstE;
    eNext.dstM  = dstM;
    eNext.srcA  = srcA;
    eNext.srcB  = srcB;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 predPC <= 64'd0;
    else if (bus.F_bubble_i)   predPC <= 64'd0;
    else if (!bus.F_stall_i)   predPC <= bus.f_predPC_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 eReg <= E_BUBBLE;
    else if (bus.E_bubble_i)   eReg <= E_BUBBLE;
    else if (!bus.E_stall_i)   eReg <= eNext;
  end

  assign bus.F_predPC_o = predPC;
  assign bus.d_srcA_o   = srcA;
  assign bus.d_srcB_o   = srcB;
  assign bus.E_stat_o   = eReg.stat;
  assign bus.E_icode_o  = eReg.icode;
  assign bus.E_ifun_o   = eReg.ifun;
  assign bus.E_valC_o   = eReg.valC;
  assign bus.E_valA_o   = eReg.valA;
  assign bus.E_valB_o   = eReg.valB;
  assign bus.E_dstE_o   = eReg.dstE;
  assign bus.E_dstM_o   = eReg.dstM;
  assign bus.E_srcA_o   = eReg.srcA;
  assign bus.E_srcB_o   = eReg.srcB;

endmodule

// File: tb/tb_y86_decode_stage.sv
// tb/tb_y86_decode_stage.sv - self-checking bench for y86_decode_stage
module tb_y86_decode_stage;
  import y86_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  bit   modelOn = 1'b0;

  y86_decode_stage_if bus ();

  y86_decode_stage dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mrf [15];
  logic [63:0] mPredPC;
  logic [2:0]  mStat;
  logic [3:0]  mIcode, mIfun, mDstE, mDstM, mSrcA, mSrcB;
  logic [63:0] mValC, mValA, mValB;

  function automatic bit inSet(input logic [3:0] ic, input logic [3:0] s[$]);
    foreach (s[k]) if (s[k] == ic) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] srcAOf(input logic [3:0] ic, input logic [3:0] ra);
    if (inSet(ic, '{4'h2, 4'h4, 4'h6, 4'hA})) return ra;
    if (inSet(ic, '{4'hB, 4'h9})) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] srcBOf(input logic [3:0] ic, input logic [3:0] rb);
    if (inSet(ic, '{4'h6, 4'h4, 4'h5})) return rb;
    if (inSet(ic, '{4'hA, 4'hB, 4'h8, 4'h9})) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] dstEOf(input logic [3:0] ic, input logic [3:0] rb);
    if (inSet(ic, '{4'h2, 4'h3, 4'h6})) return rb;
    if (inSet(ic, '{4'hA, 4'hB, 4'h8, 4'h9})) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] dstMOf(input logic [3:0] ic, input logic [3:0] ra);
    return inSet(ic, '{4'h5, 4'hB}) ? ra : 4'hF;
  endfunction

  function automatic logic [63:0] readVal(input logic [3:0] src);
    logic [3:0]  dsts [5];
    logic [63:0] vals [5];
    dsts = '{bus.e_dstE_i, bus.M_dstM_i, bus.M_dstE_i, bus.W_dstM_i, bus.W_dstE_i};
    vals = '{bus.e_valE_i, bus.m_valM_i, bus.M_valE_i, bus.W_valM_i, bus.W_valE_i};
    if (src == 4'hF) return 64'd0;
`ifdef DECODE_FORWARD_EN
    for (int k = 0; k < 5; k++) if (dsts[k] == src) return vals[k];
`endif
    return mrf[src];
  endfunction

  task automatic modelBubble();
    mStat = 3'd1; mIcode = 4'h1; mIfun = 4'h0;
    mValC = 64'd0; mValA = 64'd0; mValB = 64'd0;
    mDstE = 4'hF; mDstM = 4'hF; mSrcA = 4'hF; mSrcB = 4'hF;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) mrf[i] = 64'd0;
      mPredPC = 64'd0;
      modelBubble();
    end else begin
      logic [3:0] ic, sa, sb;
      ic = bus.D_icode_i;
      sa = srcAOf(ic, bus.D_rA_i);
      sb = srcBOf(ic, bus.D_rB_i);
      if (bus.F_bubble_i) mPredPC = 64'd0;
      else if (!bus.F_stall_i) mPredPC = bus.f_predPC_i;
      if (bus.E_bubble_i) modelBubble();
      else if (!bus.E_stall_i) begin
        mStat = bus.D_stat_i; mIcode = ic; mIfun = bus.D_ifun_i; mValC = bus.D_valC_i;
        mValA = (ic == 4'h8 || ic == 4'h7) ? bus.D_valP_i : readVal(sa);
        mValB = readVal(sb);
        mDstE = dstEOf(ic, bus.D_rB_i); mDstM = dstMOf(ic, bus.D_rA_i);
        mSrcA = sa; mSrcB = sb;
      end
      if (bus.W_dstE_i != 4'hF) mrf[bus.W_dstE_i] = bus.W_valE_i;
      if (bus.W_dstM_i != 4'hF) mrf[bus.W_dstM_i] = bus.W_valM_i;
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      chk("predPC", bus.F_predPC_o, mPredPC);
      chk("d_srcA", 64'(bus.d_srcA_o), 64'(srcAOf(bus.D_icode_i, bus.D_rA_i)));
      chk("d_srcB", 64'(bus.d_srcB_o), 64'(srcBOf(bus.D_icode_i, bus.D_rB_i)));
      chk("E_stat", 64'(bus.E_stat_o), 64'(mStat));
      chk("E_icode", 64'(bus.E_icode_o), 64'(mIcode));
      chk("E_ifun", 64'(bus.E_ifun_o), 64'(mIfun));
      chk("E_valC", bus.E_valC_o, mValC);
      chk("E_valA", bus.E_valA_o, mValA);
      chk("E_valB", bus.E_valB_o, mValB);
      chk("E_dstE", 64'(bus.E_dstE_o), 64'(mDstE));
      chk("E_dstM", 64'(bus.E_dstM_o), 64'(mDstM));
      chk("E_srcA", 64'(bus.E_srcA_o), 64'(mSrcA));
      chk("E_srcB", 64'(bus.E_srcB_o), 64'(mSrcB));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.F_stall_i = 0; bus.F_bubble_i = 0; bus.E_stall_i = 0; bus.E_bubble_i = 0;
    bus.D_stat_i = 3'd1; bus.D_icode_i = 4'h1; bus.D_ifun_i = 0;
    bus.D_rA_i = 4'hF; bus.D_rB_i = 4'hF; bus.D_valC_i = 0; bus.D_valP_i = 0;
    bus.e_dstE_i = 4'hF; bus.M_dstE_i = 4'hF; bus.M_dstM_i = 4'hF;
    bus.W_dstE_i = 4'hF; bus.W_dstM_i = 4'hF;
    bus.e_valE_i = 0; bus.M_valE_i = 0; bus.m_valM_i = 0; bus.W_valE_i = 0; bus.W_valM_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setD(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    bus.D_icode_i = ic; bus.D_rA_i = ra; bus.D_rB_i = rb;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.f_predPC_i = 64'd0;
    modelOn = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_predPC", bus.F_predPC_o, 64'd0);
    chk("rst_icode", 64'(bus.E_icode_o), 64'd1);
    chk("rst_dstE", 64'(bus.E_dstE_o), 64'hF);
    chk("rst_stat", 64'(bus.E_stat_o), 64'd1);

    // rf write then plain read
    bus.W_dstE_i = 4'd3; bus.W_valE_i = 64'h55;
    tick();
    idle();
    setD(4'h6, 4'd3, 4'hF);
    tick();
    chk("rf_read_valA", bus.E_valA_o, 64'h55);
    chk("opq_icode", 64'(bus.E_icode_o), 64'd6);

    // e beats M, then M alone
    setD(4'h6, 4'd2, 4'hF);
    bus.e_dstE_i = 4'd2; bus.e_valE_i = 64'h11;
    bus.M_dstE_i = 4'd2; bus.M_valE_i = 64'h22;
    tick();
`ifdef DECODE_FORWARD_EN
    chk("fwd_e_prio", bus.E_valA_o, 64'h11);
`else
    chk("nofwd_e", bus.E_valA_o, 64'h0);
`endif
    bus.e_dstE_i = 4'hF;
    tick();
`ifdef DECODE_FORWARD_EN
    chk("fwd_M", bus.E_valA_o, 64'h22);
`else
    chk("nofwd_M", bus.E_valA_o, 64'h0);
`endif
    idle();

    // CALL and POPQ
    setD(4'h8, 4'hF, 4'hF); bus.D_valP_i = 64'h40;
    tick();
    chk("call_valA", bus.E_valA_o, 64'h40);
    chk("call_srcB", 64'(bus.E_srcB_o), 64'd4);
    chk("call_dstE", 64'(bus.E_dstE_o), 64'd4);
    setD(4'hB, 4'd5, 4'hF);
    #1;
    chk("popq_srcA", 64'(bus.d_srcA_o), 64'd4);
    tick();
    chk("popq_dstM", 64'(bus.E_dstM_o), 64'd5);

    // E stall holds, bubble overrides stall
    setD(4'h3, 4'hF, 4'd7); bus.D_valC_i = 64'h1234;
    tick();
    bus.E_stall_i = 1; setD(4'h6, 4'd1, 4'd2); bus.D_valC_i = 64'h9;
    repeat (2) tick();
    chk("stall_icode", 64'(bus.E_icode_o), 64'd3);
    chk("stall_valC", bus.E_valC_o, 64'h1234);
    bus.E_bubble_i = 1;
    tick();
    chk("bubble_icode", 64'(bus.E_icode_o), 64'd1);
    chk("bubble_dstE", 64'(bus.E_dstE_o), 64'hF);
    idle();

    // F register
    bus.f_predPC_i = 64'h100; tick();
    chk("predPC_load", bus.F_predPC_o, 64'h100);
    bus.F_stall_i = 1; bus.f_predPC_i = 64'h200; tick();
    chk("predPC_stall", bus.F_predPC_o, 64'h100);
    bus.F_stall_i = 0; tick();
    chk("predPC_reload", bus.F_predPC_o, 64'h200);
    bus.F_bubble_i = 1; bus.F_stall_i = 1; tick();
    chk("predPC_bubble", bus.F_predPC_o, 64'h0);
    idle();

    // dual write to same register: valM wins; write to F ignored, reads of F give 0
    bus.W_dstE_i = 4'd6; bus.W_dstM_i = 4'd6; bus.W_valE_i = 64'd1; bus.W_valM_i = 64'd2;
    tick();
    idle();
    bus.W_valE_i = 64'h99;
    setD(4'h6, 4'd6, 4'hF);
    tick();
    chk("dual_write", bus.E_valA_o, 64'd2);
    setD(4'h2, 4'hF, 4'hF);
    tick();
    chk("read_rnone", bus.E_valA_o, 64'd0);
    idle();

    // mixed directed/randomised vectors checked by the model
    for (int n = 0; n < 60; n++) begin
      setD(4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      bus.D_ifun_i = 4'($urandom); bus.D_stat_i = 3'($urandom_range(1, 4));
      bus.D_valC_i = {$urandom, $urandom}; bus.D_valP_i = {$urandom, $urandom};
      bus.e_dstE_i = 4'($urandom_range(0, 15)); bus.e_valE_i = {$urandom, $urandom};
      bus.M_dstE_i = 4'($urandom_range(0, 15)); bus.M_valE_i = {$urandom, $urandom};
      bus.M_dstM_i = 4'($urandom_range(0, 15)); bus.m_valM_i = {$urandom, $urandom};
      bus.W_dstE_i = 4'($urandom_range(0, 15)); bus.W_valE_i = {$urandom, $urandom};
      bus.W_dstM_i = 4'($urandom_range(0, 15)); bus.W_valM_i = {$urandom, $urandom};
      bus.E_stall_i = ($urandom_range(0, 5) == 0);
      bus.E_bubble_i = ($urandom_range(0, 7) == 0);
      bus.F_stall_i = ($urandom_range(0, 4) == 0);
      bus.F_bubble_i = ($urandom_range(0, 9) == 0);
      bus.f_predPC_i = {$urandom, $urandom};
      tick();
    end
    idle();

    // asynchronous reset mid-run
    setD(4'h3, 4'hF, 4'd3); bus.f_predPC_i = 64'h77;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_predPC", bus.F_predPC_o, 64'd0);
    chk("arst_icode", 64'(bus.E_icode_o), 64'd1);
    chk("arst_dstE", 64'(bus.E_dstE_o), 64'hF);
    tick();
    rst = 1'b0;
    setD(4'h6, 4'd3, 4'd6);
    tick();
    chk("arst_rfA", bus.E_valA_o, 64'd0);
    chk("arst_rfB", bus.E_valB_o, 64'd0);
    tick();

    @(posedge clk);
    modelOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_decode_stage.md
# y86_decode_stage

Front half of the Y86-64 five-stage pipeline: the F predicted-PC register, the decode stage (register file, source/destination selection, operand forwarding) and the D→E pipeline register. It consumes the D-register outputs plus forwarding taps from E/M/W and produces the E-register contents and F_predPC. Stall/bubble controls come from the pipeline-control block.

## Interface
- No parameters. All widths are fixed: 64-bit data, 4-bit register IDs, 4-bit icode/ifun, 3-bit stat.
- clk_i  in  1  pipeline clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- F_stall_i, F_bubble_i  in  1 each  F register controls.
- f_predPC_i  in  64  next predicted PC. F_predPC_o  out  64.
- D_stat_i  in  3. D_icode_i, D_ifun_i, D_rA_i, D_rB_i  in  4 each. D_valC_i, D_valP_i  in  64 each.
- e_dstE_i  in  4, e_valE_i  in  64: execute-stage forward.
- M_dstE_i, M_dstM_i  in  4 each. M_valE_i, m_valM_i  in  64 each: memory-stage forwards.
- W_dstE_i, W_dstM_i  in  4 each. W_valE_i, W_valM_i  in  64 each: writeback, which is both a forward and the register-file write port.
- E_stall_i, E_bubble_i  in  1 each  E register controls.
- d_srcA_o, d_srcB_o  out  4 each  combinational, for hazard detection.
- E_stat_o  out  3. E_icode_o, E_ifun_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o  out  4 each. E_valC_o, E_valA_o, E_valB_o  out  64 each.

## Operation
- Icodes: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B. RSP = 4. RNONE = F.
- Source A (srcA):
  - rA for RRMOVQ, RMMOVQ, OPQ, PUSHQ.
  - RSP for POPQ, RET.
  - Otherwise RNONE.
- Source B (srcB):
  - rB for OPQ, RMMOVQ, MRMOVQ.
  - RSP for PUSHQ, POPQ, CALL, RET.
  - Otherwise RNONE.
- Destinations:
  - dstE = rB for RRMOVQ, IRMOVQ, OPQ; RSP for PUSHQ, POPQ, CALL, RET; otherwise RNONE.
  - dstM = rA for MRMOVQ, POPQ; otherwise RNONE.
- valA priority:
  1. D_valP if icode is CALL or JXX.
  2. Otherwise the first match of srcA against e_dstE, M_dstM, M_dstE, W_dstM, W_dstE, taking e_valE, m_valM, M_valE, W_valM, W_valE respectively.
  3. Otherwise rf[srcA].
- valB uses the same priority chain with srcB, without the valP step.
- Forwarding never matches when the source is RNONE. A read of RNONE yields 0.
- Register file: 15×64 entries. Reads are combinational with no internal write bypass; the W forward covers it.
  - Writes on the rising edge: W_valE to W_dstE, W_valM to W_dstM. Writes to RNONE are ignored.
  - If W_dstE == W_dstM, the valM write wins.
- F register: predPC loads f_predPC_i unless stalled. Bubble or reset clears it to 0.
- E register:
  - Captures stat, icode, ifun, valC, the selected valA/valB, dstE, dstM, srcA, srcB.
  - Stall holds the contents.
  - Bubble loads a NOP: stat 1 (AOK), icode 1, ifun 0, all IDs F, all values 0.
  - Bubble has priority over stall in both F and E registers.

## Timing
- Decode outputs (d_srcA_o, d_srcB_o, selected valA/valB) are purely combinational, zero latency.
- E outputs appear one clock after their D inputs. F_predPC_o appears one clock after f_predPC_i.
- Reset is asynchronous and immediate:
  - F_predPC_o = 0.
  - E register = NOP bubble value.
  - All 15 registers = 0.
- Reset release takes effect at the next rising edge.
- A register-file write at edge N is visible on combinational reads after edge N.

## Configuration
- DECODE_FORWARD_EN defined: the full e/M/W forwarding chain above is active.
- Undefined: valA = D_valP for CALL/JXX, else rf[srcA]; valB = rf[srcB]. Hazards are then resolved solely by external stalls.

## Structure
- Shared package y86_pkg holds the icode constants, RSP/RNONE, and the stat codes AOK=1, HLT=2, ADR=3, INS=4.
- One sub-module, y86_regfile: 15×64, two combinational read ports, two write ports, async reset.

## Test plan
- Reset asserted mid-run → F_predPC_o=0, E_icode_o=1, E_dstE_o=F immediately; all registers read 0 afterwards.
- W writes W_dstE=3/W_valE=0x55 at an edge; next cycle D=OPQ with rA=3 and no forward match → E_valA_o=0x55 after the following edge.
- D=OPQ rA=2, with e_dstE=2/0x11 and M_dstE=2/0x22 driven simultaneously → E_valA=0x11, showing e has priority. With e_dstE=F instead → 0x22.
- D=CALL, D_valP=0x40 → E_valA=0x40, E_srcB=4, E_dstE=4. D=POPQ rA=5 → d_srcA_o=4, E_dstM=5.
- E_stall_i held two cycles → E outputs unchanged. E_bubble_i together with E_stall_i → NOP loaded. F_stall_i → F_predPC holds while f_predPC_i changes.
- W_dstE=W_dstM=6 with valE=1, valM=2 → rf[6]=2. A write to F is ignored.
